// File: rtl/mp_add_seq_pkg.sv
// Shared constants for the multi-precision add/subtract sequencer:
// machine word width and FSM state encoding.
package mp_add_seq_pkg;

  localparam int W = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/mp_add_seq_adder.sv
// 32-bit carry-lookahead adder (adder32): 4-bit groups with group
// generate/propagate feeding the carry into the next group.
module adder32
  import mp_add_seq_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic [W-1:0] sum_o,
  output logic         c_o
);

  logic [W-1:0] g;
  logic [W-1:0] p;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    logic cy_grp;
    logic cy_bit;
    logic grp_g;
    logic grp_p;
    sum_o  = '0;
    cy_grp = c_in;
    for (int k = 0; k < W / 4; k++) begin
      cy_bit = cy_grp;
      for (int j = 0; j < 4; j++) begin
        sum_o[4*k+j] = p[4*k+j] ^ cy_bit;
        cy_bit       = g[4*k+j] | (p[4*k+j] & cy_bit);
      end
      // Group carry comes from lookahead terms, not from the in-group ripple.
      grp_g = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      grp_p  = &p[4*k +: 4];
      cy_grp = grp_g | (grp_p & cy_grp);
    end
    c_o = cy_grp;
  end

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract sequencer: one shared 32-bit adder is stepped
// over WORDS words, LSB first, with the carry held in a register between words.
module mp_add_seq
  import mp_add_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W*WORDS-1:0] a,
  input  logic [W*WORDS-1:0] b,
  input  logic               c_in,
  input  logic               sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W*WORDS-1:0] sum_o,
  output logic               c_o,
  output logic               ovf_o,
  output logic               busy,
  output logic [1:0]         state_dbg
);

  localparam int TW = W * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic          carry;
  logic [TW-1:0] op_a;
  logic [TW-1:0] op_b;

  logic [W-1:0]  add_a;
  logic [W-1:0]  add_b;
  logic [W-1:0]  add_sum;
  logic          add_co;

  assign add_a = op_a[int'(idx)*W +: W];
  assign add_b = op_b[int'(idx)*W +: W];

  adder32 u_adder (
    .a     (add_a),
    .b     (add_b),
    .c_in  (carry),
    .sum_o (add_sum),
    .c_o   (add_co)
  );

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. in_ready is high only in IDLE; out_valid is high only in DONE
  // and stays high with stable data until out_ready is seen at an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      idx   <= '0;
      carry <= 1'b0;
      op_a  <= '0;
      op_b  <= '0;
      sum_o <= '0;
      c_o   <= 1'b0;
      ovf_o <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : c_in;
            idx   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum_o[int'(idx)*W +: W] <= add_sum;
          carry                   <= add_co;
          idx                     <= idx + 1'b1;
          if (idx == LAST) begin
            idx   <= '0;
            c_o   <= add_co;
            // Overflow uses the post-inversion B sign, so it covers subtract too.
            ovf_o <= (op_a[TW-1] == op_b[TW-1]) && (add_sum[W-1] != op_a[TW-1]);
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state == ST_RUN) || (state == ST_DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_mp_add_seq.sv
// Directed-vector bench for mp_add_seq: a WORDS=2 instance for the vector
// table and backpressure, a WORDS=4 instance for reset abort and wide carries.
module tb_mp_add_seq;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] a_bus = '0;
  logic [127:0] b_bus = '0;
  logic         c_in = 1'b0;
  logic         sub = 1'b0;
  logic         out_ready = 1'b0;
  logic         iv2 = 1'b0;
  logic         iv4 = 1'b0;

  logic         ir2, ov2, c2, o2, busy2;
  logic [63:0]  sum2;
  logic [1:0]   st2;
  logic         ir4, ov4, c4, o4, busy4;
  logic [127:0] sum4;
  logic [1:0]   st4;

  int n_vec  = 0;
  int n_miss = 0;
  logic [127:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  mp_add_seq #(.WORDS(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2),
    .a(a_bus[63:0]), .b(b_bus[63:0]), .c_in(c_in), .sub(sub),
    .out_valid(ov2), .out_ready(out_ready), .sum_o(sum2), .c_o(c2),
    .ovf_o(o2), .busy(busy2), .state_dbg(st2)
  );

  mp_add_seq #(.WORDS(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4),
    .a(a_bus), .b(b_bus), .c_in(c_in), .sub(sub),
    .out_valid(ov4), .out_ready(out_ready), .sum_o(sum4), .c_o(c4),
    .ovf_o(o4), .busy(busy4), .state_dbg(st4)
  );

  // ---------------- helpers ----------------
  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic rd_ov(input bit wide);
    return wide ? ov4 : ov2;
  endfunction

  function automatic logic rd_ir(input bit wide);
    return wide ? ir4 : ir2;
  endfunction

  function automatic logic [127:0] rd_sum(input bit wide);
    return wide ? sum4 : {64'b0, sum2};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver: one full operation ----------------
  task automatic run_op(input bit wide, input logic [127:0] av, input logic [127:0] bv,
                        input logic ci, input logic sb, input logic [127:0] es,
                        input logic ec, input logic eo, input string nm);
    int cyc;
    int lat;
    logic [127:0] exp_sum;
    lat   = wide ? 4 : 2;
    a_bus = av;
    b_bus = bv;
    c_in  = ci;
    sub   = sb;
    check({nm, " in_ready"}, rd_ir(wide), 1'b1);
    if (wide) iv4 = 1'b1; else iv2 = 1'b1;
    exp_q.push_back(es);
    tick();
    iv2 = 1'b0;
    iv4 = 1'b0;
    cyc = 0;
    while (!rd_ov(wide) && cyc < 20) begin
      tick();
      cyc++;
    end
    check({nm, " latency"}, 128'(cyc), 128'(lat));
    exp_sum = exp_q.pop_front();
    check({nm, " sum"}, rd_sum(wide), exp_sum);
    check({nm, " c_o"}, wide ? c4 : c2, ec);
    check({nm, " ovf"}, wide ? o4 : o2, eo);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({nm, " release"}, {rd_ov(wide), rd_ir(wide)}, 2'b01);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        c_in;
    logic        sub;
    logic [63:0] sum;
    logic        c;
    logic        ovf;
    string       nm;
  } vec_t;

  vec_t vecs[10];

  initial begin
    bit saw_valid;
    bit saw_busy;

    vecs[0] = '{64'h00000000_FFFFFFFF, 64'h1, 1'b0, 1'b0, 64'h00000001_00000000, 1'b0, 1'b0, "word_carry"};
    vecs[1] = '{64'hFFFFFFFF_FFFFFFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, "wrap_b1"};
    vecs[2] = '{64'hFFFFFFFF_FFFFFFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, "wrap_cin"};
    vecs[3] = '{64'h5, 64'h7, 1'b1, 1'b1, 64'hFFFFFFFF_FFFFFFFE, 1'b0, 1'b0, "sub_borrow"};
    vecs[4] = '{64'h7FFFFFFF_FFFFFFFF, 64'h1, 1'b0, 1'b0, 64'h80000000_00000000, 1'b0, 1'b1, "pos_ovf"};
    vecs[5] = '{64'h7, 64'h5, 1'b0, 1'b1, 64'h2, 1'b1, 1'b0, "sub_noborrow"};
    vecs[6] = '{64'h80000000_00000000, 64'h80000000_00000000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, "neg_ovf"};
    vecs[7] = '{64'h80000000_00000000, 64'h1, 1'b0, 1'b1, 64'h7FFFFFFF_FFFFFFFF, 1'b1, 1'b1, "sub_ovf"};
    vecs[8] = '{64'h12345678_9ABCDEF0, 64'h11111111_11111111, 1'b1, 1'b0, 64'h23456789_ABCDF002, 1'b0, 1'b0, "add_cin"};
    vecs[9] = '{64'h0, 64'h0, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0, "sub_zero"};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst sum2", {64'b0, sum2}, 128'h0);
    check("rst flags2", {c2, o2, ov2, busy2, ir2, st2}, 7'b0000_1_00);
    check("rst flags4", {c4, o4, ov4, busy4, ir4, st4}, 7'b0000_1_00);
    rst = 1'b0;
    tick();

    // table vectors on WORDS=2
    for (int i = 0; i < 10; i++) begin
      run_op(1'b0, {64'b0, vecs[i].a}, {64'b0, vecs[i].b}, vecs[i].c_in, vecs[i].sub,
             {64'b0, vecs[i].sum}, vecs[i].c, vecs[i].ovf, vecs[i].nm);
    end

    // backpressure in DONE with an ignored in_valid pulse
    a_bus = 128'h00000000_FFFFFFFF;
    b_bus = 128'h1;
    c_in  = 1'b0;
    sub   = 1'b0;
    iv2   = 1'b1;
    tick();
    iv2 = 1'b0;
    tick();
    tick();
    check("bp valid_at_2", ov2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        a_bus = 128'h11111111_11111111;
        iv2   = 1'b1;
      end
      tick();
      iv2 = 1'b0;
      check("bp hold", {ov2, ir2, st2}, 4'b1_0_10);
      check("bp sum stable", {64'b0, sum2}, 128'h00000001_00000000);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp release", {ov2, ir2, busy2}, 3'b010);
    check("bp sum held", {64'b0, sum2}, 128'h00000001_00000000);
    saw_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (busy2) saw_busy = 1'b1;
    end
    check("bp pulse not queued", saw_busy, 1'b0);

    // reset mid-RUN on WORDS=4
    a_bus = 128'h0000000A_0000000B_0000000C_FFFFFFFF;
    b_bus = 128'h1;
    c_in  = 1'b0;
    sub   = 1'b0;
    iv4   = 1'b1;
    tick();
    iv4 = 1'b0;
    tick();
    check("mid partial w0", sum4[31:0], 32'h0);
    tick();
    check("mid partial w1", sum4[63:32], 32'h0000000D);
    check("mid busy", {busy4, st4}, 3'b1_01);
    rst = 1'b1;
    #1;
    check("mid rst sum", sum4, 128'h0);
    check("mid rst flags", {c4, o4, ov4, busy4, ir4, st4}, 7'b0000_1_00);
    tick();
    rst = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ov4 || busy4) saw_valid = 1'b1;
    end
    check("mid no out_valid", saw_valid, 1'b0);

    // WORDS=4 operations after the abort
    run_op(1'b1, 128'h0000000A_0000000B_0000000C_FFFFFFFF, 128'h1, 1'b0, 1'b0,
           128'h0000000A_0000000B_0000000D_00000000, 1'b0, 1'b0, "w4 after_rst");
    run_op(1'b1, {128{1'b1}}, 128'h1, 1'b0, 1'b0, 128'h0, 1'b1, 1'b0, "w4 wrap");
    run_op(1'b1, 128'h0, 128'h1, 1'b0, 1'b1, {128{1'b1}}, 1'b0, 1'b0, "w4 sub");
    run_op(1'b1, 128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'h1, 1'b0, 1'b0,
           128'h80000000_00000000_00000000_00000000, 1'b0, 1'b1, "w4 ovf");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mp_add_seq.md
# mp_add_seq

Multi-precision add/subtract sequencer. It computes WORDS×32-bit sums over several cycles by driving one existing 32-bit carry-lookahead adder (`adder32`), one word per cycle, LSB word first, with the carry chained through a register. The block sits between a requesting datapath (valid/ready input) and a consumer (valid/ready output). It lets wide arithmetic share a single 32-bit adder instead of instantiating a wide one.

## Interface
- WORDS, 4, number of 32-bit words per operand; legal range 2..16
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  requester presents an operation
- in_ready  out  1  block can accept; high only in IDLE
- a  in  32*WORDS  operand A, sampled on accept
- b  in  32*WORDS  operand B, sampled on accept
- c_in  in  1  carry-in for add; ignored when sub=1
- sub  in  1  0: A+B+c_in; 1: A−B, computed as A+~B+1
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- sum_o  out  32*WORDS  result
- c_o  out  1  carry out of the top word (for sub, 1 = no borrow)
- ovf_o  out  1  signed overflow of the full-width result
- busy  out  1  high in RUN or DONE

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid, the block latches a, b (inverted when sub=1) and the initial carry (sub ? 1 : c_in), sets idx=0, and goes to RUN.
- RUN: the adder receives word idx of A, word idx of B, and the carry register. On each edge the adder sum is written to result word idx, carry ← adder c_o, and idx++. When idx==WORDS−1 the last word is written and the state goes to DONE.
- DONE: out_valid=1. sum_o, c_o and ovf_o are held stable. When out_ready=1 the result is consumed and the state returns to IDLE.
- c_o is the carry register value after the last word.
- ovf_o = (A_msb == B'_msb) && (sum_msb != A_msb), where B' is the post-inversion operand.
- sum_o, c_o and ovf_o are registered. They keep the last result until the next result is written; partial words become visible during RUN.
- in_ready is held low in RUN and DONE. in_valid in those states is ignored, not queued.
- Reset values: state=IDLE, idx=0, carry=0, sum_o=0, c_o=0, ovf_o=0, out_valid=0, busy=0, in_ready=1.
- Reset mid-operation aborts the operation immediately. No out_valid follows and the latched operands are discarded.

## Timing
- The accept edge is cycle 0. RUN spans edges 1..WORDS. out_valid rises after edge WORDS.
- out_ready must be held high at an edge in DONE for the handshake to complete. Earliest next accept is at edge WORDS+2.
- Minimum initiation interval is WORDS+2 cycles with out_ready tied high.
- The adder path is combinational within one cycle. Critical path is the 32-bit CLA plus the word mux plus the carry register.
- out_valid is held until the handshake completes. out_ready while not out_valid has no effect.

## Structure
- Shared package holds the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the word width constant W=32.
- One sub-module: the existing `adder32` (a, b, c_in, sum_o, c_o), instantiated once and unmodified.
- Word select uses an idx-indexed part-select. The idx width is clog2(WORDS).

## Test plan
- WORDS=2, add: a=64'h00000000_FFFFFFFF, b=64'h1, c_in=0 -> sum_o=64'h00000001_00000000, c_o=0, ovf_o=0, out_valid 2 cycles after accept.
- WORDS=2, full wrap: a=64'hFFFFFFFF_FFFFFFFF, b=64'h1, c_in=0 -> sum_o=0, c_o=1, ovf_o=0. With c_in=1 and b=0, the result is the same.
- WORDS=2, subtract: a=64'h5, b=64'h7, sub=1, c_in=1 (ignored) -> sum_o=64'hFFFFFFFF_FFFFFFFE, c_o=0, ovf_o=0.
- WORDS=2, signed overflow: a=64'h7FFFFFFF_FFFFFFFF, b=64'h1 -> sum_o=64'h80000000_00000000, ovf_o=1, c_o=0.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> out_valid stays 1, sum_o stable, in_ready=0, and an in_valid pulse is ignored. out_ready=1 returns the block to IDLE next cycle.
- Reset mid-RUN: WORDS=4, assert rst after edge 2 -> all outputs return to reset values at once, with no out_valid. A subsequent operation completes correctly.
